bin2bcd_seq: RTL and testbench

//   Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble).

---
 rtl/bin2bcd_seq.sv | 107 ++++++++++
 tb/tb_bin2bcd_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one adjust-and-shift step per clock.
// Digit outputs are registered and hold the last result until the next conversion completes.
module bin2bcd_seq #(
  parameter int N_BITS   = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_BITS-1:0]     bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd
);

  localparam int CW = $clog2(N_BITS + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [N_BITS-1:0]       shreg_r;
  logic [4*N_DIGITS-1:0]   scratch_r;
  logic [CW-1:0]           cnt_r;
  logic [4*N_DIGITS-1:0]   scratch_nxt_s;
  logic [N_BITS-1:0]       shreg_nxt_s;

  // Adjust each digit (>=5 gets +3), then shift the scratch left by one taking in_bit as LSB.
  // The carry out of the top digit is dropped; it cannot be set for a legal N_DIGITS.
  function automatic logic [4*N_DIGITS-1:0] shift_adjust(
    input logic [4*N_DIGITS-1:0] scratch,
    input logic                  in_bit
  );
    logic [4*N_DIGITS-1:0] result;
    logic [3:0]            digit;
    logic                  carry;
    result = '0;
    carry  = in_bit;
    for (int i = 0; i < N_DIGITS; i++) begin
      digit = (scratch[4*i +: 4] >= 4'd5) ? (scratch[4*i +: 4] + 4'd3) : scratch[4*i +: 4];
      result[4*i +: 4] = {digit[2:0], carry};
      carry = digit[3];
    end
    return result;
  endfunction

  // Next scratch/shift values for one double-dabble step
  always_comb begin
    scratch_nxt_s = shift_adjust(scratch_r, shreg_r[N_BITS-1]);
    shreg_nxt_s   = {shreg_r[N_BITS-2:0], 1'b0};
  end

  // Control FSM with registered busy/done/bcd outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      shreg_r   <= '0;
      scratch_r <= '0;
      cnt_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            shreg_r   <= bin;
            scratch_r <= '0;
            cnt_r     <= CNT_INIT;
            busy      <= 1'b1;
            state_r   <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          scratch_r <= scratch_nxt_s;
          shreg_r   <= shreg_nxt_s;
          cnt_r     <= cnt_r - CNT_LAST;
          if (cnt_r == CNT_LAST) begin
            bcd     <= scratch_nxt_s;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= SHIFT;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: scoreboard of expected digits, decimal reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int          checks   = 0;
  int          failures = 0;
  logic [19:0] exp_q[$];

  bin2bcd_seq #(.N_BITS(16), .N_DIGITS(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    r = 20'd0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the done pulse; reports edges consumed
  task automatic wait_done(output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      cycles++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin = 16'd0;
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (bcd !== 20'h0) begin failures++; $display("FAIL reset_bcd: got %h expected 00000", bcd); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single(input int v);
    int cyc;
    bit seen;
    logic [19:0] e;
    exp_q.push_back(to_bcd(v));
    bin = 16'(v); start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy(%0d): got %b expected 1", v, busy); end
    wait_done(cyc, seen);
    checks++;
    if (!seen) begin
      failures++; $display("FAIL single_timeout(%0d): no done within 40 cycles", v);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (bcd !== e) begin failures++; $display("FAIL single_bcd(%0d): got %h expected %h", v, bcd, e); end
      checks++; if (cyc + 1 !== 17) begin failures++; $display("FAIL single_latency(%0d): got %0d expected 17", v, cyc + 1); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_at_done(%0d): got %b expected 0", v, busy); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_pulse(%0d): got %b expected 0", v, done); end
      checks++; if (bcd !== e) begin failures++; $display("FAIL single_hold(%0d): got %h expected %h", v, bcd, e); end
    end
  endtask

  task automatic test_values();
    int vals[4] = '{65535, 1234, 9999, 7};
    foreach (vals[i]) test_single(vals[i]);
  endtask

  task automatic test_async_reset();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (bcd !== 20'h0) begin failures++; $display("FAIL async_rst_bcd: got %h expected 00000", bcd); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_rst_ctl: got busy=%b done=%b expected 0/0", busy, done); end
    #2 rst = 1'b0;
  endtask

  task automatic test_ignore_start();
    int cyc;
    bit seen;
    bin = 16'd100; start = 1'b1;
    tick();
    cyc  = 1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      start = i[0];
      bin   = 16'd500;
      tick();
      cyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      failures++; $display("FAIL ignore_timeout: no done within 40 cycles");
    end else begin
      if (bcd !== to_bcd(100)) begin failures++; $display("FAIL ignore_bcd: got %h expected %h", bcd, to_bcd(100)); end
      checks++; if (cyc !== 17) begin failures++; $display("FAIL ignore_latency: got %0d expected 17", cyc); end
    end
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ignore_second_conv: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_back_to_back();
    int last = 0;
    int ndone = 0;
    int nxt = 1;
    logic [19:0] e;
    bin = 16'd0; start = 1'b1;
    exp_q.push_back(to_bcd(0));
    for (int c = 1; c <= 200 && ndone < 4; c++) begin
      tick();
      if (done) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_overlap: busy=%b with done=1", busy); end
        e = exp_q.pop_front();
        checks++; if (bcd !== e) begin failures++; $display("FAIL b2b_bcd: got %h expected %h", bcd, e); end
        checks++; if (c - last !== 17) begin failures++; $display("FAIL b2b_period: got %0d expected 17", c - last); end
        last = c;
        ndone++;
        if (ndone < 4) begin
          bin = 16'(nxt);
          exp_q.push_back(to_bcd(nxt));
          nxt++;
        end else begin
          start = 1'b0;
        end
      end else begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: cycle %0d got %b expected 1", c, busy); end
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 4) begin failures++; $display("FAIL b2b_count: got %0d expected 4", ndone); end
    exp_q.delete();
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    bin = 16'd54321; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    checks++; if (bcd !== 20'h0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst: got bcd=%h busy=%b expected 00000/0", bcd, busy); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_rst_done: got done pulse expected none"); end
    checks++; if (bcd !== 20'h0) begin failures++; $display("FAIL mid_rst_bcd: got %h expected 00000", bcd); end
    test_single(54321);
  endtask

  initial begin
    test_reset();
    test_single(0);
    test_values();
    test_async_reset();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
